// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array sequencer: state encoding,
// default array geometry and lane slicing helpers.
package systolic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam int ARR_ROWS = 8;
  localparam int ARR_COLS = 8;
  localparam int ARR_DW   = 8;
  localparam int ARR_KW   = 16;

  function automatic int drain_cycles(input int rows, input int cols);
    return rows + cols;
  endfunction

  localparam int DRAIN_CYCLES = drain_cycles(ARR_ROWS, ARR_COLS);

  // Low bit of lane 'lane' in a flattened bus of 'width'-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Operand beat stream into the sequencer: one A column and one B row per beat.
interface systolic_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int COLS       = 8
);

  logic                       in_valid;
  logic                       in_ready;
  logic [ROWS*DATA_WIDTH-1:0] in_a;
  logic [COLS*DATA_WIDTH-1:0] in_b;

  modport master (output in_valid, output in_a, output in_b, input in_ready);
  modport slave  (input in_valid, input in_a, input in_b, output in_ready);

endinterface

// File: rtl/skew_line.sv
// Fixed-depth shift chain for one array edge lane; DEPTH 0 is a plain wire.
module skew_line #(
  parameter int DEPTH      = 0,
  parameter int DATA_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic signed [DATA_WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, clr};
    assign dout = din;
  end else begin : g_chain
    logic [DEPTH-1:0][DATA_WIDTH-1:0] pipe_p;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe_p <= '0;
      end else if (clr) begin
        pipe_p <= '0;
      end else begin
        pipe_p[0] <= din;
        for (int s = 1; s < DEPTH; s++) pipe_p[s] <= pipe_p[s-1];
      end
    end

    assign dout = $signed(pipe_p[DEPTH-1]);
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Job sequencer for the output-stationary PE array: clear, skewed feed,
// pipeline drain and capture of the finished C tile.
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = ARR_DW,
  parameter int ROWS       = ARR_ROWS,
  parameter int COLS       = ARR_COLS,
  parameter int K_WIDTH    = ARR_KW
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic [K_WIDTH-1:0]                  k_len,
  output logic                                busy,
  output logic                                done,
  systolic_ctrl_if.slave                      op,
  output logic                                arr_rst_n,
  output logic                                arr_en,
  output logic [ROWS*DATA_WIDTH-1:0]          arr_a,
  output logic [COLS*DATA_WIDTH-1:0]          arr_b,
  input  logic [ROWS*COLS*2*DATA_WIDTH-1:0]   arr_c,
  output logic [ROWS*COLS*2*DATA_WIDTH-1:0]   c_out
);

  localparam int DRAIN_LEN = drain_cycles(ROWS, COLS);
  localparam int DRAIN_W   = (DRAIN_LEN > 2) ? $clog2(DRAIN_LEN) : 1;

  state_e               state, state_nx;
  logic [K_WIDTH-1:0]   k_len_q;
  logic [K_WIDTH-1:0]   k_cnt;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic                 accept;
  logic                 skew_clr;

  assign accept   = op.in_valid && op.in_ready;
  assign skew_clr = !(state == S_FEED || state == S_DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    busy        = (state != S_IDLE);
    arr_en      = (state == S_FEED);
    op.in_ready = (state == S_FEED) && (k_cnt < k_len_q);
    case (state)
      S_IDLE:  if (start) state_nx = S_CLEAR;
      S_CLEAR: state_nx = (k_len_q == '0) ? S_DONE : S_FEED;
      S_FEED:  if (accept && (k_cnt == k_len_q - K_WIDTH'(1))) state_nx = S_DRAIN;
      S_DRAIN: if (drain_cnt == '0) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Control registers; arr_rst_n is low exactly while the FSM sits in CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_len_q   <= '0;
      k_cnt     <= '0;
      drain_cnt <= '0;
      arr_rst_n <= 1'b1;
      done      <= 1'b0;
      c_out     <= '0;
    end else begin
      arr_rst_n <= (state_nx != S_CLEAR);
      done      <= (state == S_DONE);
      if (state == S_IDLE && start) k_len_q <= k_len;
      if (state == S_CLEAR)  k_cnt <= '0;
      else if (accept)       k_cnt <= k_cnt + K_WIDTH'(1);
      if (state == S_FEED && state_nx == S_DRAIN)   drain_cnt <= DRAIN_W'(DRAIN_LEN - 1);
      else if (state == S_DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - DRAIN_W'(1);
      if (state == S_DONE) c_out <= arr_c;
    end
  end

  // Edge skew: lane n of each operand is delayed n cycles so that A(i,k)
  // and B(k,j) meet at PE(i,j) on the same cycle.
  for (genvar i = 0; i < ROWS; i++) begin : g_a
    logic signed [DATA_WIDTH-1:0] lane_in, lane_out;
    assign lane_in = accept ? $signed(op.in_a[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH]) : '0;
    skew_line #(.DEPTH(i), .DATA_WIDTH(DATA_WIDTH)) u_skew (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (skew_clr),
      .din  (lane_in),
      .dout (lane_out)
    );
    assign arr_a[lane_lo(i, DATA_WIDTH) +: DATA_WIDTH] = lane_out;
  end

  for (genvar j = 0; j < COLS; j++) begin : g_b
    logic signed [DATA_WIDTH-1:0] lane_in, lane_out;
    assign lane_in = accept ? $signed(op.in_b[lane_lo(j, DATA_WIDTH) +: DATA_WIDTH]) : '0;
    skew_line #(.DEPTH(j), .DATA_WIDTH(DATA_WIDTH)) u_skew (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (skew_clr),
      .din  (lane_in),
      .dout (lane_out)
    );
    assign arr_b[lane_lo(j, DATA_WIDTH) +: DATA_WIDTH] = lane_out;
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl on a 4x4 array with a behavioural PE array model.
module tb_systolic_ctrl;
  import systolic_pkg::*;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int KW = 16;
  localparam int CW = R*C*2*DW;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            busy, done, arr_rst_n, arr_en;
  logic [R*DW-1:0] arr_a;
  logic [C*DW-1:0] arr_b;
  logic [CW-1:0]   arr_c, c_out;

  systolic_ctrl_if #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C)) ifc ();

  systolic_ctrl #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C), .K_WIDTH(KW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .k_len    (k_len),
    .busy     (busy),
    .done     (done),
    .op       (ifc),
    .arr_rst_n(arr_rst_n),
    .arr_en   (arr_en),
    .arr_a    (arr_a),
    .arr_b    (arr_b),
    .arr_c    (arr_c),
    .c_out    (c_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output-stationary array model: A moves right, B moves down, each PE accumulates.
  logic signed [DW-1:0]   m_a  [R][C];
  logic signed [DW-1:0]   m_b  [R][C];
  logic signed [2*DW-1:0] m_acc[R][C];
  logic signed [DW-1:0]   pa   [R][C];
  logic signed [DW-1:0]   pb   [R][C];

  always_comb begin
    pa = '{default: '0};
    pb = '{default: '0};
    for (int i = 0; i < R; i++) begin
      for (int j = 0; j < C; j++) begin
        if (j == 0) pa[i][j] = $signed(arr_a[i*DW +: DW]);
        else        pa[i][j] = m_a[i][(j > 0) ? j-1 : 0];
        if (i == 0) pb[i][j] = $signed(arr_b[j*DW +: DW]);
        else        pb[i][j] = m_b[(i > 0) ? i-1 : 0][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < R; i++) begin
      for (int j = 0; j < C; j++) begin
        if (!rst_n || !arr_rst_n) begin
          m_a[i][j]   <= '0;
          m_b[i][j]   <= '0;
          m_acc[i][j] <= '0;
        end else begin
          m_a[i][j]   <= pa[i][j];
          m_b[i][j]   <= pb[i][j];
          m_acc[i][j] <= m_acc[i][j] + (2*DW)'(pa[i][j]) * (2*DW)'(pb[i][j]);
        end
      end
    end
  end

  always_comb begin
    arr_c = '0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        arr_c[(i*C+j)*2*DW +: 2*DW] = m_acc[i][j];
  end

  typedef struct {
    logic [CW-1:0] c;
    int            cyc;
  } exp_t;

  exp_t          sb_q[$];
  int            checks = 0;
  int            errors = 0;
  int            clr_cnt = 0;
  int            feed_gap = 0;
  logic [CW-1:0] exp_c;
  logic [R*DW-1:0] va[4];
  logic [C*DW-1:0] vb[4];

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [R*DW-1:0] pack4(input int v0, input int v1, input int v2, input int v3);
    logic [R*DW-1:0] r;
    r[0*DW +: DW] = DW'(v0);
    r[1*DW +: DW] = DW'(v1);
    r[2*DW +: DW] = DW'(v2);
    r[3*DW +: DW] = DW'(v3);
    return r;
  endfunction

  task automatic set_el(input int i, input int j, input int v);
    exp_c[(i*C+j)*2*DW +: 2*DW] = (2*DW)'(v);
  endtask

  // Monitor: pops an expectation for every done pulse.
  initial begin
    exp_t e;
    bit   done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        clr_cnt   = 0;
        done_prev = 1'b0;
      end else begin
        if (done_prev) chk("done_pulse_width", CW'(done), CW'(0));
        if (arr_en && !ifc.in_ready) feed_gap++;
        if (!arr_rst_n) clr_cnt++;
        if (done) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d, want no pulse", cyc);
          end else begin
            e = sb_q.pop_front();
            chk("c_out", c_out, e.c);
            chk("done_cycle", CW'(cyc), CW'(e.cyc));
            chk("clear_pulses", CW'(clr_cnt), CW'(1));
          end
          clr_cnt = 0;
        end
        done_prev = done;
      end
    end
  end

  task automatic start_job(input int k, input bit push, input int lat);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(k);
    @(posedge clk);
    #1;
    if (push) begin
      e.c   = exp_c;
      e.cyc = cyc + lat;
      sb_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [R*DW-1:0] a, input logic [C*DW-1:0] b, input bit pulse);
    int n;
    n = 0;
    @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_a     = a;
    ifc.in_b     = b;
    start        = pulse;
    if (pulse) k_len = '0;
    while (!ifc.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL beat_accept: got no in_ready in %0d cycles, want acceptance", n);
    end
    @(posedge clk);
  endtask

  task automatic run_job(input int k, input int bub, input bit push, input int lat, input int pulse_beat);
    start_job(k, push, lat);
    for (int b = 0; b < k; b++) begin
      send_beat(va[b], vb[b], b == pulse_beat);
      if (bub > 0 && b < k-1) begin
        @(negedge clk);
        start = 1'b0;
        ifc.in_valid = 1'b0;
        repeat (bub-1) @(negedge clk);
      end
    end
    @(negedge clk);
    start = 1'b0;
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL job_timeout: got %0d pending results, want 0", sb_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic skew_watch();
    int n;
    n = 0;
    @(negedge clk);
    #1;
    while (!(ifc.in_valid && ifc.in_ready) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("skew_a0_accept", CW'(arr_a[0 +: DW]), CW'(1));
    chk("skew_b0_accept", CW'(arr_b[0 +: DW]), CW'(1));
    chk("skew_a3_d0", CW'(arr_a[3*DW +: DW]), CW'(0));
    @(negedge clk); #1;
    chk("skew_a1_d1", CW'(arr_a[1*DW +: DW]), CW'(2));
    chk("skew_a3_d1", CW'(arr_a[3*DW +: DW]), CW'(0));
    @(negedge clk); #1;
    chk("skew_a3_d2", CW'(arr_a[3*DW +: DW]), CW'(0));
    chk("skew_b3_d2", CW'(arr_b[3*DW +: DW]), CW'(0));
    @(negedge clk); #1;
    chk("skew_a3_d3", CW'(arr_a[3*DW +: DW]), CW'(4));
    chk("skew_b3_d3", CW'(arr_b[3*DW +: DW]), CW'(4));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation time limit, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t6[16];
    t6 = '{11, 12, 13, 14, 12, 14, 16, 18, 13, 16, 19, 22, 14, 18, 22, 26};
    rst_n = 1'b0;
    start = 1'b0;
    k_len = '0;
    ifc.in_valid = 1'b0;
    ifc.in_a = '0;
    ifc.in_b = '0;
    exp_c = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",      CW'(busy),        CW'(0));
    chk("rst_done",      CW'(done),        CW'(0));
    chk("rst_in_ready",  CW'(ifc.in_ready), CW'(0));
    chk("rst_arr_en",    CW'(arr_en),      CW'(0));
    chk("rst_arr_rst_n", CW'(arr_rst_n),   CW'(1));
    chk("rst_arr_a",     CW'(arr_a),       CW'(0));
    chk("rst_arr_b",     CW'(arr_b),       CW'(0));
    chk("rst_c_out",     c_out,            '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic 2x2 product in the top-left corner, continuous beats.
    va[0] = pack4(1, 3, 0, 0);  va[1] = pack4(2, 4, 0, 0);
    vb[0] = pack4(5, 6, 0, 0);  vb[1] = pack4(7, 8, 0, 0);
    exp_c = '0;
    set_el(0, 0, 19); set_el(0, 1, 22); set_el(1, 0, 43); set_el(1, 1, 50);
    run_job(2, 0, 1'b1, 12, -1);
    wait_done();

    // Same job with two bubble cycles between the beats.
    feed_gap = 0;
    run_job(2, 2, 1'b1, 14, -1);
    wait_done();
    chk("in_ready_in_feed", CW'(feed_gap), CW'(0));

    // Zero-length job.
    exp_c = '0;
    run_job(0, 0, 1'b1, 2, -1);
    wait_done();

    // Signed corner with a stray start during the third FEED cycle.
    for (int b = 0; b < 3; b++) begin
      va[b] = pack4(-128, -128, -128, -128);
      vb[b] = pack4(-128, -128, -128, -128);
    end
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        set_el(i, j, 49152);
    run_job(3, 0, 1'b1, 13, 2);
    wait_done();

    // Asynchronous reset in the middle of FEED aborts the job silently.
    va[0] = pack4(1, 3, 0, 0);  va[1] = pack4(2, 4, 0, 0);
    vb[0] = pack4(5, 6, 0, 0);  vb[1] = pack4(7, 8, 0, 0);
    start_job(2, 1'b0, 0);
    send_beat(va[0], vb[0], 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy",      CW'(busy),         CW'(0));
    chk("abort_in_ready",  CW'(ifc.in_ready), CW'(0));
    chk("abort_arr_en",    CW'(arr_en),       CW'(0));
    chk("abort_arr_rst_n", CW'(arr_rst_n),    CW'(1));
    chk("abort_arr_a",     CW'(arr_a),        CW'(0));
    chk("abort_c_out",     c_out,             '0);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    exp_c = '0;
    set_el(0, 0, 19); set_el(0, 1, 22); set_el(1, 0, 43); set_el(1, 1, 50);
    run_job(2, 0, 1'b1, 12, -1);
    wait_done();

    // Full 4x4 job: C(i,j) = (i+1)(j+1) + 10, with skew timing on lane 3.
    va[0] = pack4(1, 2, 3, 4);  va[1] = pack4(1, 1, 1, 1);
    vb[0] = pack4(1, 2, 3, 4);  vb[1] = pack4(10, 10, 10, 10);
    exp_c = '0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        set_el(i, j, t6[i*C+j]);
    fork
      run_job(2, 0, 1'b1, 12, -1);
      skew_watch();
    join
    wait_done();

    chk("scoreboard_drained", CW'(sb_q.size()), CW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
